// File: rtl/iob_soc_opencryptolinux_mem_arbiter_if.sv
// IOb native bus bundle shared by the arbiter's requester and memory sides.
// The master modport belongs to whoever issues requests; slave answers them.
interface iob_soc_opencryptolinux_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  avalid;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wstrb;
  logic [DATA_W-1:0]     rdata;
  logic                  rvalid;
  logic                  ready;

  modport master (
    output avalid, addr, wdata, wstrb,
    input  rdata, rvalid, ready
  );

  modport slave (
    input  avalid, addr, wdata, wstrb,
    output rdata, rvalid, ready
  );
endinterface

// File: rtl/iob_soc_opencryptolinux_mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single IOb memory port.
// One transaction in flight; reads may complete in XFER or wait in WAIT_R.
module iob_soc_opencryptolinux_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                                          clk_i,
  input  logic                                          rst_i,
  iob_soc_opencryptolinux_mem_arbiter_if.slave          m0_iob,
  iob_soc_opencryptolinux_mem_arbiter_if.slave          m1_iob,
  iob_soc_opencryptolinux_mem_arbiter_if.master         s_iob,
  output logic [1:0]                                    grant_o,
  output logic                                          busy_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    XFER   = 2'd1,
    WAIT_R = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic              ptr_q, ptr_d;   // index of the requester served last

  logic                own;
  logic                own_avalid;
  logic [ADDR_W-1:0]   own_addr;
  logic [DATA_W-1:0]   own_wdata;
  logic [DATA_W/8-1:0] own_wstrb;

  logic                rsp_ready;
  logic                rsp_rvalid;
  logic [DATA_W-1:0]   rsp_rdata;

  always_comb begin
    own        = grant_q[1];
    own_avalid = own ? m1_iob.avalid : m0_iob.avalid;
    own_addr   = own ? m1_iob.addr   : m0_iob.addr;
    own_wdata  = own ? m1_iob.wdata  : m0_iob.wdata;
    own_wstrb  = own ? m1_iob.wstrb  : m0_iob.wstrb;
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    s_iob.avalid = 1'b0;
    s_iob.addr   = '0;
    s_iob.wdata  = '0;
    s_iob.wstrb  = '0;
    rsp_ready   = 1'b0;
    rsp_rvalid  = 1'b0;
    rsp_rdata   = '0;

    unique case (state_q)
      IDLE: begin
        if (m0_iob.avalid && m1_iob.avalid) begin
          grant_d = ptr_q ? 2'b01 : 2'b10;
          state_d = XFER;
        end else if (m0_iob.avalid) begin
          grant_d = 2'b01;
          state_d = XFER;
        end else if (m1_iob.avalid) begin
          grant_d = 2'b10;
          state_d = XFER;
        end
      end

      XFER: begin
        s_iob.avalid = own_avalid;
        s_iob.addr   = own_addr;
        s_iob.wdata  = own_wdata;
        s_iob.wstrb  = own_wstrb;
        rsp_ready    = s_iob.ready;
        // A dropped avalid abandons the request without crediting the owner.
        if (!own_avalid) begin
          state_d = IDLE;
          grant_d = '0;
        end else if (s_iob.ready) begin
          if (|own_wstrb) begin
            state_d = IDLE;
            grant_d = '0;
            ptr_d   = own;
          end else if (s_iob.rvalid) begin
            rsp_rvalid = 1'b1;
            rsp_rdata  = s_iob.rdata;
            state_d    = IDLE;
            grant_d    = '0;
            ptr_d      = own;
          end else begin
            state_d = WAIT_R;
          end
        end
      end

      WAIT_R: begin
        if (s_iob.rvalid) begin
          rsp_rvalid = 1'b1;
          rsp_rdata  = s_iob.rdata;
          state_d    = IDLE;
          grant_d    = '0;
          ptr_d      = own;
        end
      end

      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  // Response channels are only live in XFER/WAIT_R, where grant_q is one-hot.
  assign m0_iob.ready  = rsp_ready  & grant_q[0];
  assign m0_iob.rvalid = rsp_rvalid & grant_q[0];
  assign m0_iob.rdata  = grant_q[0] ? rsp_rdata : '0;
  assign m1_iob.ready  = rsp_ready  & grant_q[1];
  assign m1_iob.rvalid = rsp_rvalid & grant_q[1];
  assign m1_iob.rdata  = grant_q[1] ? rsp_rdata : '0;

  assign grant_o = grant_q;
  assign busy_o  = (state_q != IDLE);

endmodule

// File: tb/tb_iob_soc_opencryptolinux_mem_arbiter.sv
// Directed bench for the two-requester memory arbiter.
module tb_iob_soc_opencryptolinux_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] grant;
  logic       busy;

  iob_soc_opencryptolinux_mem_arbiter_if m0_if ();
  iob_soc_opencryptolinux_mem_arbiter_if m1_if ();
  iob_soc_opencryptolinux_mem_arbiter_if s_if ();

  iob_soc_opencryptolinux_mem_arbiter #(
    .ADDR_W (32),
    .DATA_W (32)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .m0_iob  (m0_if),
    .m1_iob  (m1_if),
    .s_iob   (s_if),
    .grant_o (grant),
    .busy_o  (busy)
  );

  always #5 clk = ~clk;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic clear_inputs();
    m0_if.avalid = 1'b0; m0_if.addr = '0; m0_if.wdata = '0; m0_if.wstrb = '0;
    m1_if.avalid = 1'b0; m1_if.addr = '0; m1_if.wdata = '0; m1_if.wstrb = '0;
    s_if.ready = 1'b0; s_if.rvalid = 1'b0; s_if.rdata = '0;
  endtask

  initial begin
    logic [1:0] eg;
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    settle();
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_s_avalid", s_if.avalid, 0);
    chk("rst_m0_ready", m0_if.ready, 0);
    chk("rst_m1_rvalid", m1_if.rvalid, 0);

    // Single write from m0
    tick();
    rst = 1'b0;
    m0_if.avalid = 1'b1; m0_if.addr = 32'h100; m0_if.wdata = 32'hA5A5A5A5; m0_if.wstrb = 4'hF;
    settle();
    chk("wr_t_s_avalid", s_if.avalid, 0);
    chk("wr_t_grant", grant, 0);
    tick();
    settle();
    chk("wr_t1_s_avalid", s_if.avalid, 1);
    chk("wr_t1_s_addr", s_if.addr, 32'h100);
    chk("wr_t1_s_wdata", s_if.wdata, 32'hA5A5A5A5);
    chk("wr_t1_s_wstrb", s_if.wstrb, 32'hF);
    chk("wr_t1_grant", grant, 32'h1);
    chk("wr_t1_m0_ready", m0_if.ready, 0);
    tick();
    s_if.ready = 1'b1;
    settle();
    chk("wr_t2_m0_ready", m0_if.ready, 1);
    chk("wr_t2_m1_ready", m1_if.ready, 0);
    chk("wr_t2_grant", grant, 32'h1);
    tick();
    clear_inputs();
    s_if.ready = 1'b1; s_if.rvalid = 1'b1; s_if.rdata = 32'hFFFF0000;
    settle();
    chk("wr_t3_grant", grant, 0);
    chk("wr_t3_busy", busy, 0);
    chk("idle_ign_m0_ready", m0_if.ready, 0);
    chk("idle_ign_m0_rvalid", m0_if.rvalid, 0);
    chk("idle_ign_m0_rdata", m0_if.rdata, 0);

    // Read by m1 with 3-cycle response latency
    tick();
    clear_inputs();
    m1_if.avalid = 1'b1; m1_if.addr = 32'h40;
    settle();
    tick();
    s_if.ready = 1'b1;
    settle();
    chk("rd3_grant", grant, 32'h2);
    chk("rd3_m1_ready", m1_if.ready, 1);
    chk("rd3_s_addr", s_if.addr, 32'h40);
    chk("rd3_busy_x", busy, 1);
    tick();
    m1_if.avalid = 1'b0; s_if.ready = 1'b0;
    settle();
    chk("rd3_w1_s_avalid", s_if.avalid, 0);
    chk("rd3_w1_s_addr", s_if.addr, 0);
    chk("rd3_w1_m1_ready", m1_if.ready, 0);
    chk("rd3_w1_grant", grant, 32'h2);
    chk("rd3_w1_busy", busy, 1);
    tick();
    settle();
    chk("rd3_w2_m1_rvalid", m1_if.rvalid, 0);
    chk("rd3_w2_busy", busy, 1);
    tick();
    s_if.rvalid = 1'b1; s_if.rdata = 32'h12345678;
    settle();
    chk("rd3_m1_rvalid", m1_if.rvalid, 1);
    chk("rd3_m1_rdata", m1_if.rdata, 32'h12345678);
    chk("rd3_m0_rvalid", m0_if.rvalid, 0);
    chk("rd3_m0_rdata", m0_if.rdata, 0);
    chk("rd3_busy_r", busy, 1);
    tick();
    s_if.rvalid = 1'b0; s_if.rdata = '0;
    settle();
    chk("rd3_after_m1_rvalid", m1_if.rvalid, 0);
    chk("rd3_after_busy", busy, 0);

    // Zero-latency read by m0
    tick();
    m0_if.avalid = 1'b1; m0_if.addr = 32'h200; m0_if.wstrb = '0;
    settle();
    tick();
    s_if.ready = 1'b1; s_if.rvalid = 1'b1; s_if.rdata = 32'hCAFEF00D;
    settle();
    chk("rd0_m0_rvalid", m0_if.rvalid, 1);
    chk("rd0_m0_rdata", m0_if.rdata, 32'hCAFEF00D);
    chk("rd0_m0_ready", m0_if.ready, 1);
    tick();
    clear_inputs();
    settle();
    chk("rd0_next_busy", busy, 0);

    // Continuous contention straight out of reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m0_if.avalid = 1'b1; m0_if.wstrb = 4'hF; m0_if.addr = 32'h10;
    m1_if.avalid = 1'b1; m1_if.wstrb = 4'hF; m1_if.addr = 32'h20;
    s_if.ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      settle();
      if (c % 2 == 0) eg = 2'b00;
      else eg = ((c / 2) % 2 == 0) ? 2'b01 : 2'b10;
      chk($sformatf("cont_grant_%0d", c), grant, eg);
      chk($sformatf("cont_m0_ready_%0d", c), m0_if.ready, eg[0]);
      chk($sformatf("cont_m1_ready_%0d", c), m1_if.ready, eg[1]);
      tick();
    end
    clear_inputs();

    // Reset during WAIT_R, late response discarded
    m1_if.avalid = 1'b1; m1_if.addr = 32'h44;
    settle();
    tick();
    s_if.ready = 1'b1;
    settle();
    chk("rstw_m1_ready", m1_if.ready, 1);
    tick();
    m1_if.avalid = 1'b0; s_if.ready = 1'b0; rst = 1'b1;
    settle();
    chk("rstw_wait_busy", busy, 1);
    chk("rstw_wait_grant", grant, 32'h2);
    tick();
    rst = 1'b0; s_if.rvalid = 1'b1; s_if.rdata = 32'hDEADBEEF;
    settle();
    chk("rstw_m1_rvalid", m1_if.rvalid, 0);
    chk("rstw_m1_rdata", m1_if.rdata, 0);
    chk("rstw_m0_rvalid", m0_if.rvalid, 0);
    chk("rstw_busy", busy, 0);
    chk("rstw_grant", grant, 0);
    tick();
    s_if.rvalid = 1'b0; s_if.rdata = '0;
    m0_if.avalid = 1'b1; m0_if.wstrb = 4'hF; m0_if.addr = 32'h50;
    m1_if.avalid = 1'b1; m1_if.wstrb = 4'hF; m1_if.addr = 32'h60;
    settle();
    chk("rstw_tie_idle_grant", grant, 0);
    tick();
    s_if.ready = 1'b1;
    settle();
    chk("rstw_tie_grant", grant, 32'h1);
    chk("rstw_tie_m0_ready", m0_if.ready, 1);
    chk("rstw_tie_m1_ready", m1_if.ready, 0);
    chk("rstw_tie_m1_rdata", m1_if.rdata, 0);
    tick();
    m0_if.avalid = 1'b0; s_if.ready = 1'b0;
    settle();
    chk("idle_grant", grant, 0);
    chk("idle_s_avalid", s_if.avalid, 0);
    chk("idle_s_wstrb", s_if.wstrb, 0);
    chk("idle_s_addr", s_if.addr, 0);

    // Abort by m1 with m0 pending
    tick();
    m1_if.avalid = 1'b0;
    m0_if.avalid = 1'b1; m0_if.addr = 32'h300;
    settle();
    chk("abort_grant", grant, 32'h2);
    chk("abort_s_avalid", s_if.avalid, 0);
    chk("abort_m0_ready", m0_if.ready, 0);
    tick();
    m1_if.avalid = 1'b1;
    settle();
    chk("abort_idle_busy", busy, 0);
    chk("abort_idle_grant", grant, 0);
    tick();
    s_if.ready = 1'b1;
    settle();
    chk("abort_ptr_grant", grant, 32'h2);
    chk("abort_m1_ready", m1_if.ready, 1);
    tick();
    m1_if.avalid = 1'b0; s_if.ready = 1'b0;
    settle();
    chk("abort_gap_grant", grant, 0);
    tick();
    s_if.ready = 1'b1;
    settle();
    chk("abort_m0_grant", grant, 32'h1);
    chk("abort_m0_addr", s_if.addr, 32'h300);
    chk("abort_m0_served", m0_if.ready, 1);
    tick();
    clear_inputs();
    settle();
    chk("end_busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
